// File: rtl/crypt_result_buf_if.sv
// rtl/crypt_result_buf_if.sv - write/read handshake bundle for crypt_result_buf.
// Optional C_par exists only with CRYPT_RESULT_PARITY_EN.
interface crypt_result_buf_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                           ena;
  logic                           load;
  logic [WIDTH-1:0]               R_i;
  logic                           clear;
  logic                           C_ready;
  logic [WIDTH-1:0]               C_ex;
  logic                           C_valid;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic                           full;
  logic                           empty;
  logic                           ovf;
`ifdef CRYPT_RESULT_PARITY_EN
  logic                           C_par;
`endif

  modport master (
    output ena, load, R_i, clear, C_ready,
    input  C_ex, C_valid, count, full, empty, ovf
`ifdef CRYPT_RESULT_PARITY_EN
    , input C_par
`endif
  );

  modport slave (
    input  ena, load, R_i, clear, C_ready,
    output C_ex, C_valid, count, full, empty, ovf
`ifdef CRYPT_RESULT_PARITY_EN
    , output C_par
`endif
  );
endinterface

// File: rtl/crypt_result_buf.sv
// rtl/crypt_result_buf.sv - FIFO buffer for crypt core ciphertext words with sticky overflow.
// Optional per-word parity output C_par is enabled by defining CRYPT_RESULT_PARITY_EN.
module crypt_result_buf #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  crypt_result_buf_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;
  logic             drop;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign pop  = !empty_w && bus.C_ready && !bus.clear;
  assign push = bus.ena && bus.load && !bus.clear && (!full_w || pop);
  assign drop = bus.ena && bus.load && !bus.clear && !push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.clear) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Storage is deliberately unreset; C_ex is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.R_i;
  end

  assign bus.C_ex    = empty_w ? '0 : mem[rptr];
  assign bus.C_valid = !empty_w;
  assign bus.count   = count_q;
  assign bus.full    = full_w;
  assign bus.empty   = empty_w;
  assign bus.ovf     = ovf_q;

`ifdef CRYPT_RESULT_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) par_mem[wptr] <= ^bus.R_i;
  end

  assign bus.C_par = empty_w ? 1'b0 : par_mem[rptr];
`endif
endmodule

// File: tb/tb_crypt_result_buf.sv
// tb/tb_crypt_result_buf.sv - scoreboard bench for crypt_result_buf (WIDTH=4, DEPTH=4).
// Parity checks are compiled in when CRYPT_RESULT_PARITY_EN is defined.
module tb_crypt_result_buf;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  crypt_result_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  crypt_result_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  logic [WIDTH-1:0] sb_q [$];
  bit m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [WIDTH-1:0] head;
    head = (sb_q.size() > 0) ? sb_q[0] : '0;
    check_eq({tag, "_count"}, 32'(bus.count), 32'(sb_q.size()));
    check_eq({tag, "_valid"}, 32'(bus.C_valid), 32'(sb_q.size() > 0));
    check_eq({tag, "_empty"}, 32'(bus.empty), 32'(sb_q.size() == 0));
    check_eq({tag, "_full"}, 32'(bus.full), 32'(sb_q.size() == DEPTH));
    check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(m_ovf));
    check_eq({tag, "_cex"}, 32'(bus.C_ex), 32'(head));
`ifdef CRYPT_RESULT_PARITY_EN
    check_eq({tag, "_cpar"}, 32'(bus.C_par), 32'(^head));
`endif
  endtask

  // One clock: drive inputs, predict push/pop, compare popped head, then check post-edge state.
  task automatic step(input bit en, input bit ld, input logic [WIDTH-1:0] d,
                      input bit rdy, input bit clr, input string tag);
    bit m_pop;
    bit m_push;
    logic [WIDTH-1:0] exp_head;
    bus.ena     = en;
    bus.load    = ld;
    bus.R_i     = d;
    bus.C_ready = rdy;
    bus.clear   = clr;
    #1;
    m_pop  = (sb_q.size() > 0) && rdy && !clr;
    m_push = en && ld && !clr && ((sb_q.size() < DEPTH) || m_pop);
    if (m_pop) begin
      exp_head = sb_q.pop_front();
      check_eq({tag, "_head"}, 32'(bus.C_ex), 32'(exp_head));
    end
    if (clr) begin
      sb_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_push) sb_q.push_back(d);
      if (en && ld && !m_push) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle_steps(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, rdy, 1'b0, tag);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    m_ovf       = 1'b0;
    bus.ena     = 1'b0;
    bus.load    = 1'b0;
    bus.R_i     = '0;
    bus.clear   = 1'b0;
    bus.C_ready = 1'b0;
    rst         = 1'b1;
    #12;
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three writes held, then drained in order.
    step(1, 1, 4'h3, 0, 0, "r32_w0");
    step(1, 1, 4'h5, 0, 0, "r32_w1");
    step(1, 1, 4'h9, 0, 0, "r32_w2");
    check_eq("r32_count3", 32'(bus.count), 32'd3);
    check_eq("r32_head3", 32'(bus.C_ex), 32'h3);
    idle_steps(3, 1'b1, "r32_rd");
    check_eq("r32_empty", 32'(bus.empty), 32'd1);
    check_eq("r32_cex0", 32'(bus.C_ex), 32'd0);

    // Overflow drop and sticky flag.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 4'(i + 1), 0, 0, "r33_fill");
    step(1, 1, 4'hA, 0, 0, "r33_drop");
    check_eq("r33_ovf", 32'(bus.ovf), 32'd1);
    check_eq("r33_count", 32'(bus.count), 32'd4);
    idle_steps(DEPTH, 1'b1, "r33_drain");
    check_eq("r33_ovf_sticky", 32'(bus.ovf), 32'd1);
    step(0, 0, '0, 0, 1, "r33_clear");
    check_eq("r33_ovf_cleared", 32'(bus.ovf), 32'd0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 4'(i + 1), 0, 0, "r34_fill");
    step(1, 1, 4'hB, 1, 0, "r34_pp");
    check_eq("r34_count", 32'(bus.count), 32'd4);
    check_eq("r34_ovf", 32'(bus.ovf), 32'd0);
    idle_steps(DEPTH, 1'b1, "r34_drain");

    // Disabled writes, then clear beating a push.
    for (int i = 0; i < 3; i++) step(0, 1, 4'hC, 0, 0, "r35_dis");
    check_eq("r35_count", 32'(bus.count), 32'd0);
    step(1, 1, 4'h6, 0, 0, "r35_w0");
    step(1, 1, 4'h7, 0, 0, "r35_w1");
    step(1, 1, 4'h8, 1, 1, "r35_clr");
    check_eq("r35_cex", 32'(bus.C_ex), 32'd0);

    // Asynchronous reset between edges.
    step(1, 1, 4'h1, 0, 0, "r36_w0");
    step(1, 1, 4'h2, 0, 0, "r36_w1");
    step(1, 1, 4'h3, 0, 0, "r36_w2");
    #2 rst = 1'b1;
    #1;
    sb_q.delete();
    m_ovf = 1'b0;
    check_eq("r36_rst_count", 32'(bus.count), 32'd0);
    check_eq("r36_rst_valid", 32'(bus.C_valid), 32'd0);
    #1 rst = 1'b0;
    step(1, 1, 4'h5, 0, 0, "r36_after");
    check_eq("r36_after_cex", 32'(bus.C_ex), 32'h5);
`ifdef CRYPT_RESULT_PARITY_EN
    step(1, 1, 4'h7, 1, 0, "par_7");
    check_eq("par_7_bit", 32'(bus.C_par), 32'd1);
    step(1, 1, 4'h3, 1, 0, "par_3");
    check_eq("par_3_bit", 32'(bus.C_par), 32'd0);
`endif

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(3) != 0), $urandom_range(1) == 1, 4'($urandom_range(15)),
           $urandom_range(1) == 1, ($urandom_range(19) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
